seq_div_unit: RTL and testbench

//   Multi-cycle unsigned restoring divider for the calculator ALU.
//   It is the subtract/inverse-direction companion to the carry-lookahead adder path.
//   One quotient bit per clock is produced via a trial subtraction.

---
 rtl/seq_div_unit.sv | 101 ++++++++++
 tb/tb_seq_div_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_div_unit.sv
// seq_div_unit: multi-cycle unsigned restoring divider, one quotient bit per clock.
module seq_div_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dsr_q, dsr_d;
  logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
  logic busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH:0] trial, diff;
  logic accept, ge;
  // dvd_q shifts the dividend out at the top while quotient bits enter at the bottom
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    trial   = {rem_q, dvd_q[WIDTH-1]};
    diff    = trial - {1'b0, dsr_q};
    ge      = ~diff[WIDTH];
    accept  = start && (state_q != CALC);
    if (accept) begin
      dvd_d = dividend;
      dsr_d = divisor;
      rem_d = '0;
      dbz_d = (divisor == '0);
      if (divisor == '0) begin
        state_d = DONE;
        done_d  = 1'b1;
        quo_d   = '1;
        rmd_d   = dividend;
      end else begin
        state_d = CALC;
        busy_d  = 1'b1;
        cnt_d   = CW'(WIDTH - 1);
      end
    end else if (state_q == CALC) begin
      rem_d = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      dvd_d = {dvd_q[WIDTH-2:0], ge};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        quo_d   = dvd_d;
        rmd_d   = rem_d;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_div_unit.sv
// tb_seq_div_unit: directed and random checks of seq_div_unit against an arithmetic model.
module tb_seq_div_unit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [7:0] quotient, remainder;
  int n_tests = 0, n_fail = 0;

  seq_div_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
    int q, r;
    q = (b == 0) ? 255 : a / b;
    r = (b == 0) ? a : a % b;
    return {q[7:0], r[7:0], b == 0};
  endfunction

  // Pulses start for one cycle; returns at the falling edge after the accepting edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
  endtask

  // Counts falling edges until done is seen (1 = already high), bounded.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 1; busy_cnt = 0;
    while (done !== 1'b1 && lat < 30) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_tests++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0", {busy, done, quotient, remainder, div_by_zero});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic(input logic [7:0] a, input logic [7:0] b);
    int lat, bc;
    launch(a, b);
    wait_done(lat, bc);
    n_tests++;
    if (lat !== 9 || bc !== 8 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_timing %0d/%0d got lat=%0d busy_cycles=%0d want lat=9 busy_cycles=8", a, b, lat, bc);
    end
    n_tests++;
    if ({quotient, remainder, div_by_zero} !== model(a, b)) begin
      n_fail++;
      $display("FAIL basic_result %0d/%0d got=%h want=%h", a, b, {quotient, remainder, div_by_zero}, model(a, b));
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse got=%b want=0", done);
    end
  endtask

  task automatic test_div_zero;
    int lat, bc;
    launch(8'd42, 8'd0);
    wait_done(lat, bc);
    n_tests++;
    if (lat !== 1 || bc !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dbz_timing got lat=%0d busy_cycles=%0d want lat=1 busy_cycles=0", lat, bc);
    end
    n_tests++;
    if ({quotient, remainder, div_by_zero} !== {8'd255, 8'd42, 1'b1}) begin
      n_fail++;
      $display("FAIL dbz_result got=%h want=%h", {quotient, remainder, div_by_zero}, {8'd255, 8'd42, 1'b1});
    end
    launch(8'd9, 8'd4);
    wait_done(lat, bc);
    n_tests++;
    if ({quotient, remainder, div_by_zero} !== {8'd2, 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL dbz_clear got=%h want=%h", {quotient, remainder, div_by_zero}, {8'd2, 8'd1, 1'b0});
    end
  endtask

  task automatic test_start_while_busy;
    int lat, bc;
    launch(8'd100, 8'd7);
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    n_tests++;
    if (lat !== 8 || {quotient, remainder, div_by_zero} !== {8'd14, 8'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL busy_ignore got lat=%0d res=%h want lat=8 res=%h", lat, {quotient, remainder, div_by_zero}, {8'd14, 8'd2, 1'b0});
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_no_queue got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc, seen;
    launch(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got=%h want=0", {busy, done, quotient, remainder, div_by_zero});
    end
    seen = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet got activity_cycles=%0d want 0", seen);
    end
    test_basic(8'd100, 8'd7);
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    launch(8'd100, 8'd7);
    wait_done(lat, bc);
    n_tests++;
    if ({quotient, remainder} !== {8'd14, 8'd2}) begin
      n_fail++;
      $display("FAIL b2b_first got=%h want=%h", {quotient, remainder}, {8'd14, 8'd2});
    end
    start = 1'b1; dividend = 8'd77; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    n_tests++;
    if (lat !== 9 || {quotient, remainder, div_by_zero} !== {8'd15, 8'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_second got lat=%0d res=%h want lat=9 res=%h", lat, {quotient, remainder, div_by_zero}, {8'd15, 8'd2, 1'b0});
    end
  endtask

  task automatic test_random;
    int lat, bc, errs;
    logic [7:0] a, b;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      launch(a, b);
      wait_done(lat, bc);
      n_tests++;
      if ({quotient, remainder, div_by_zero} !== model(a, b) || lat !== ((b == 0) ? 1 : 9)) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL random %0d/%0d got=%h lat=%0d want=%h", a, b, {quotient, remainder, div_by_zero}, lat, model(a, b));
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic(8'd100, 8'd7);
    test_basic(8'd255, 8'd1);
    test_basic(8'd5, 8'd9);
    test_basic(8'd0, 8'd3);
    test_div_zero;
    test_start_while_busy;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
